// File: rtl/seq_div8_pkg.sv
// rtl/seq_div8_pkg.sv - shared width, counter size and FSM state encoding for seq_div8
package seq_div8_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div8_div_step.sv
// rtl/seq_div8_div_step.sv - combinational one-bit restoring division step
module seq_div8_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next,
    output logic             qbit
);

    // Add/subtract primitive: A + ~B + 1, carry-out means no borrow.
    logic [WIDTH+1:0] sum;

    always_comb begin
        sum    = {1'b0, r, next_bit} + {1'b0, ~{1'b0, divisor}} + (WIDTH+2)'(1);
        // With R < divisor the difference never reaches bit WIDTH on a no-borrow step.
        qbit   = sum[WIDTH+1] & ~sum[WIDTH];
        r_next = qbit ? sum[WIDTH-1:0] : {r[WIDTH-2:0], next_bit};
    end

endmodule

// File: rtl/seq_div8.sv
// rtl/seq_div8.sv - sequential unsigned restoring divider with start/busy/done handshake
module seq_div8
    import seq_div8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] d_reg, dvs_reg, r_reg, q_reg;
    logic             zero_op;
    logic             accept, finish;
    logic [WIDTH-1:0] step_r;
    logic             step_q;

    seq_div8_div_step #(.WIDTH(WIDTH)) u_step (
        .r        (r_reg),
        .next_bit (d_reg[WIDTH-1]),
        .divisor  (dvs_reg),
        .r_next   (step_r),
        .qbit     (step_q)
    );

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                accept     = 1'b1;
                next_state = S_ITER;
            end
            S_ITER: if (cnt == CNT_LAST) begin
                finish     = 1'b1;
                next_state = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            d_reg       <= '0;
            dvs_reg     <= '0;
            r_reg       <= '0;
            q_reg       <= '0;
            zero_op     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != S_IDLE);
            done  <= finish;
            if (accept) begin
                d_reg   <= dividend;
                dvs_reg <= divisor;
                r_reg   <= '0;
                q_reg   <= '0;
                zero_op <= (divisor == '0);
                // A zero divisor skips the iterations and completes on the next edge.
                cnt     <= (divisor == '0) ? CNT_LAST : '0;
            end else if (state == S_ITER) begin
                d_reg <= {d_reg[WIDTH-2:0], 1'b0};
                r_reg <= step_r;
                q_reg <= {q_reg[WIDTH-2:0], step_q};
                cnt   <= cnt + 1'b1;
            end
            if (finish) begin
                quotient    <= zero_op ? '1 : {q_reg[WIDTH-2:0], step_q};
                remainder   <= zero_op ? d_reg : step_r;
                div_by_zero <= zero_op;
            end
        end
    end

endmodule

// File: tb/tb_seq_div8.sv
// tb/tb_seq_div8.sv - randomized self-checking bench for seq_div8 against an arithmetic model
module tb_seq_div8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    int checks = 0;
    int failures = 0;

    seq_div8 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [7:0] b);
        return (b == 0) ? 8'hFF : 8'(int'(a) / int'(b));
    endfunction

    function automatic logic [7:0] ref_r(input logic [7:0] a, input logic [7:0] b);
        return (b == 0) ? a : 8'(int'(a) % int'(b));
    endfunction

    // Issue one operation at the next negedge; lat is the index of the edge after
    // the accept edge on which done was registered (0 on timeout).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r, output logic dz,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
        lat = 0; busy_ok = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = n - 1;
                break;
            end
        end
        q = quotient; r = remainder; dz = div_by_zero;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%0b done=%0b q=%0d r=%0d dz=%0b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_200_7();
        logic [7:0] q, r; logic dz; int lat; bit bok;
        run_op(8'd200, 8'd7, q, r, dz, lat, bok);
        checks++;
        if (lat !== 8) begin failures++; $display("FAIL lat_200_7 got %0d want 8", lat); end
        checks++;
        if ({q, r, dz} !== {8'd28, 8'd4, 1'b0}) begin
            failures++; $display("FAIL res_200_7 got q=%0d r=%0d dz=%0b want 28 4 0", q, r, dz);
        end
        checks++;
        if (!bok) begin failures++; $display("FAIL busy_200_7 got busy low during op want high"); end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++; $display("FAIL after_200_7 got busy=%0b done=%0b want 0 0", busy, done);
        end
    endtask

    task automatic test_corners();
        logic [7:0] tab_a[4] = '{8'd255, 8'd5, 8'd0, 8'd255};
        logic [7:0] tab_b[4] = '{8'd1, 8'd9, 8'd3, 8'd255};
        logic [7:0] want_q[4] = '{8'd255, 8'd0, 8'd0, 8'd1};
        logic [7:0] want_r[4] = '{8'd0, 8'd5, 8'd0, 8'd0};
        logic [7:0] q, r; logic dz; int lat; bit bok;
        for (int i = 0; i < 4; i++) begin
            run_op(tab_a[i], tab_b[i], q, r, dz, lat, bok);
            checks++;
            if ({q, r, dz} !== {want_q[i], want_r[i], 1'b0} || lat !== 8) begin
                failures++;
                $display("FAIL corner_%0d_%0d got q=%0d r=%0d dz=%0b lat=%0d want %0d %0d 0 8",
                         tab_a[i], tab_b[i], q, r, dz, lat, want_q[i], want_r[i]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        logic [7:0] q, r; logic dz; int lat; bit bok;
        run_op(8'd77, 8'd0, q, r, dz, lat, bok);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL lat_div0 got %0d want 1", lat); end
        checks++;
        if ({q, r, dz} !== {8'd255, 8'd77, 1'b1}) begin
            failures++; $display("FAIL res_div0 got q=%0d r=%0d dz=%0b want 255 77 1", q, r, dz);
        end
        run_op(8'd9, 8'd2, q, r, dz, lat, bok);
        checks++;
        if ({q, r, dz} !== {8'd4, 8'd1, 1'b0}) begin
            failures++; $display("FAIL res_after_div0 got q=%0d r=%0d dz=%0b want 4 1 0", q, r, dz);
        end
    endtask

    task automatic test_start_while_busy();
        int pulses = 0;
        int done_at = 0;
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd3;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 3) begin start = 1'b1; dividend = 8'd50; divisor = 8'd5; end
            if (done) begin
                pulses++;
                if (done_at == 0) begin
                    done_at = n - 1;
                    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
                    checks++;
                    if ({quotient, remainder, div_by_zero} !== {8'd33, 8'd1, 1'b0}) begin
                        failures++;
                        $display("FAIL res_busy_ignore got q=%0d r=%0d want 33 1", quotient, remainder);
                    end
                end
            end
            if (done_at != 0 && n == done_at + 2) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++; $display("FAIL busy_after_ignore got busy=%0b want 0", busy);
                end
            end
        end
        checks++;
        if (pulses !== 1 || done_at !== 8) begin
            failures++; $display("FAIL pulses_busy_ignore got pulses=%0d at=%0d want 1 at 8", pulses, done_at);
        end
    endtask

    task automatic test_reset_mid_op();
        int pulses = 0;
        logic [7:0] q, r; logic dz; int lat; bit bok;
        @(negedge clk);
        start = 1'b1; dividend = 8'd250; divisor = 8'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            failures++;
            $display("FAIL reset_mid_op got busy=%0b done=%0b q=%0d r=%0d dz=%0b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin failures++; $display("FAIL no_done_after_rst got %0d pulses want 0", pulses); end
        run_op(8'd250, 8'd6, q, r, dz, lat, bok);
        checks++;
        if ({q, r, dz} !== {8'd41, 8'd4, 1'b0}) begin
            failures++; $display("FAIL res_after_rst got q=%0d r=%0d dz=%0b want 41 4 0", q, r, dz);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q, r, a, b; logic dz; int lat; bit bok;
        int bad = 0;
        for (int i = 0; i < 700; i++) begin
            a = 8'($urandom);
            b = (i % 16 == 0) ? 8'd0 : 8'($urandom);
            if (i % 37 == 1) b = 8'd1;
            run_op(a, b, q, r, dz, lat, bok);
            checks++;
            if ({q, r, dz} !== {ref_q(a, b), ref_r(a, b), b == 0} || lat !== ((b == 0) ? 1 : 8) || !bok) begin
                failures++;
                if (bad < 10)
                    $display("FAIL sweep %0d/%0d got q=%0d r=%0d dz=%0b lat=%0d want %0d %0d %0b %0d",
                             a, b, q, r, dz, lat, ref_q(a, b), ref_r(a, b), b == 0, (b == 0) ? 1 : 8);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_200_7();
        test_corners();
        test_div_by_zero();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
